ace_line_port: RTL
==================

// Module: ace_line_port
// PURPOSE
//  Parametrised ACE master port for whole-cache-line transactions; replaces single-beat AR/AW/W/R/B sequencing.
//  Accepts one line request from the cache controller and runs the ACE burst on AR/R or AW/W/B.
//  Delivers fill beats to the cache datapath, fetches writeback beats from it, and reports IsShared/PassDirty/error.
//  Issues RACK/WACK. Sits between cache_controller/cache_datapath and the interconnect; snoop channels are out of scope.
// PARAMETERS
//  WIDTH_A     32  address width
//  WIDTH_D     32  data beat width; power of 2, >= 8
//  LINE_WORDS  4   beats per cache line; power of 2, 1..16
// PORTS
//  clk         in   1        clock, all logic on rising edge
//  rst         in   1        synchronous, active-high reset
//  req_valid   in   1        line request valid
//  req_ready   out  1        port idle; request accepted when req_valid&req_ready
//  req_op      in   2        0 READ_SHARED, 1 READ_UNIQUE, 2 MAKE_UNIQUE, 3 WRITE_BACK
//  req_addr    in   WIDTH_A  any address in the line; low bits forced to line alignment
//  fill_valid  out  1        one pulse per accepted R data beat (not for MAKE_UNIQUE)
//  fill_idx    out  $clog2(LINE_WORDS)  beat index of fill_data (min width 1)
//  fill_data   out  WIDTH_D  registered RDATA
//  wb_idx      out  $clog2(LINE_WORDS)  beat index requested from the datapath
//  wb_data     in   WIDTH_D  datapath word at wb_idx; combinational, same cycle
//  done        out  1        one-cycle pulse: transaction complete
//  resp_err    out  1        valid with done: any RRESP[1:0]/BRESP!=0, or R_LAST misplaced
//  resp_shared out  1        valid with done: RRESP[3] (IsShared) of last beat
//  resp_dirty  out  1        valid with done: RRESP[2] (PassDirty) of last beat
//  AR_VALID/AR_READY/AR_ADDR/AR_LEN/AR_SIZE/AR_BURST/AR_SNOOP[3:0]/AR_DOMAIN  ACE read address
//  R_VALID/R_READY/RDATA/R_LAST/RRESP[3:0]  ACE read data;  RACK out 1  read acknowledge
//  AW_VALID/AW_READY/AW_ADDR/AW_LEN/AW_SIZE/AW_BURST/AW_SNOOP[2:0]/AW_DOMAIN  ACE write address
//  W_VALID/W_READY/W_DATA/W_LAST; B_VALID/B_READY/BRESP[1:0];  WACK out 1  write acknowledge
// BEHAVIOUR
//  Reset: all VALIDs, READYs, RACK, WACK, done, fill_valid, resp_* = 0; req_ready=1; FSM=IDLE; counters=0.
//  FSM: IDLE -> AR (ops 0-2) or AW (op 3) on accept; opcode and aligned address latched at accept.
//       AR -> R on AR handshake; R -> ACK on accepted beat with R_LAST.
//       AW -> W on AW handshake; W -> B after last W handshake; B -> ACK on B handshake.
//       ACK: RACK or WACK =1 for exactly one cycle, done=1 in the same cycle; -> IDLE. req_ready=1 only in IDLE.
//  AR: LEN=LINE_WORDS-1 (MAKE_UNIQUE: LEN=0); SIZE=$clog2(WIDTH_D/8); BURST=INCR(2'b01); DOMAIN=2'b01.
//      AR_SNOOP: ReadShared 4'b0001, ReadUnique 4'b0111, MakeUnique 4'b1100.
//      AW: LEN=LINE_WORDS-1, AW_SNOOP WriteBack 3'b011, same SIZE/BURST/DOMAIN.
//  VALIDs held asserted with stable payload until handshake; never depend on READY.
//  R: R_READY=1 throughout state R. Beat counter increments per handshake; fill_idx=counter, output 1 cycle after beat.
//     R_LAST before beat LINE_WORDS-1 or absent at it: resp_err=1; transaction still ends only at R_LAST.
//     Counter saturates at LINE_WORDS-1; extra beats are not forwarded.
//  W: wb_idx=W beat counter; W_DATA=wb_data; W_LAST=(counter==LINE_WORDS-1); W_VALID continuous in W.
//  B: B_READY=1 in state B only. Error flags sticky from accept to done, cleared at next accept.
//  Back-to-back: new request accepted the cycle after done (IDLE); no overlapping transactions.
//  rst mid-burst: immediate return to reset values; in-flight interconnect beats are not drained.
// STRUCTURE
//  Package ace_line_pkg: req_op_e, ace_state_e, AR/AW snoop encodings, DOMAIN_INNER, BURST_INCR constants.
//  Single module; optional sub-module ace_beat_counter (param LINE_WORDS, inc/clr/last) shared by R and W paths.
// TESTING
//  READ_SHARED @0x1234, LINE_WORDS=4, AR_READY after 2 cyc -> AR_ADDR=0x1230, LEN=3, 4 fill pulses idx 0..3, RACK+done.
//  R beats with RRESP=4'b1000 on last beat -> done with resp_shared=1, resp_dirty=0, resp_err=0.
//  WRITE_BACK @0x2000, W_READY toggling 1/0 -> W_DATA=wb_data[0..3] in order, W_LAST on 4th only, WACK+done after B.
//  MAKE_UNIQUE -> AR_SNOOP=4'b1100, LEN=0, no fill_valid, done after single R beat.
//  R_LAST on beat 2 of 4 -> resp_err=1, done at that beat; BRESP=2'b10 -> resp_err=1.
//  rst asserted during W beat 2 -> next cycle all VALIDs=0, req_ready=1; fresh READ_UNIQUE runs cleanly.

Source files
------------

// File: rtl/ace_line_pkg.sv
// Shared types and ACE encodings for the whole-line ACE master port.
package ace_line_pkg;

  typedef enum logic [1:0] {
    OP_READ_SHARED = 2'd0,
    OP_READ_UNIQUE = 2'd1,
    OP_MAKE_UNIQUE = 2'd2,
    OP_WRITE_BACK  = 2'd3
  } req_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_ACK
  } ace_state_e;

  localparam logic [3:0] AR_SNOOP_READ_SHARED = 4'b0001;
  localparam logic [3:0] AR_SNOOP_READ_UNIQUE = 4'b0111;
  localparam logic [3:0] AR_SNOOP_MAKE_UNIQUE = 4'b1100;
  localparam logic [2:0] AW_SNOOP_WRITE_BACK  = 3'b011;
  localparam logic [1:0] DOMAIN_INNER         = 2'b01;
  localparam logic [1:0] BURST_INCR           = 2'b01;

  function automatic logic [3:0] ar_snoop_of(input req_op_e op);
    logic [3:0] snoop;
    snoop = AR_SNOOP_READ_SHARED;
    case (op)
      OP_READ_UNIQUE: snoop = AR_SNOOP_READ_UNIQUE;
      OP_MAKE_UNIQUE: snoop = AR_SNOOP_MAKE_UNIQUE;
      default:        snoop = AR_SNOOP_READ_SHARED;
    endcase
    return snoop;
  endfunction

endpackage

// File: rtl/ace_beat_counter.sv
// Beat counter for one line burst; saturates at the last beat and flags any beat seen beyond it.
module ace_beat_counter #(
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [IW-1:0] cnt,
  output logic          last,
  output logic          full
);

  localparam logic [IW-1:0] LAST_IDX = IW'(LINE_WORDS - 1);

  assign last = (cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      full <= 1'b0;
    end else if (inc) begin
      if (last) full <= 1'b1;
      else      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ace_line_port.sv
// ACE master port running whole-cache-line read (AR/R) and writeback (AW/W/B) bursts.
module ace_line_port
  import ace_line_pkg::*;
#(
  parameter int unsigned WIDTH_A    = 32,
  parameter int unsigned WIDTH_D    = 32,
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [WIDTH_A-1:0] req_addr,
  output logic               fill_valid,
  output logic [IW-1:0]      fill_idx,
  output logic [WIDTH_D-1:0] fill_data,
  output logic [IW-1:0]      wb_idx,
  input  logic [WIDTH_D-1:0] wb_data,
  output logic               done,
  output logic               resp_err,
  output logic               resp_shared,
  output logic               resp_dirty,
  output logic               AR_VALID,
  input  logic               AR_READY,
  output logic [WIDTH_A-1:0] AR_ADDR,
  output logic [7:0]         AR_LEN,
  output logic [2:0]         AR_SIZE,
  output logic [1:0]         AR_BURST,
  output logic [3:0]         AR_SNOOP,
  output logic [1:0]         AR_DOMAIN,
  input  logic               R_VALID,
  output logic               R_READY,
  input  logic [WIDTH_D-1:0] RDATA,
  input  logic               R_LAST,
  input  logic [3:0]         RRESP,
  output logic               RACK,
  output logic               AW_VALID,
  input  logic               AW_READY,
  output logic [WIDTH_A-1:0] AW_ADDR,
  output logic [7:0]         AW_LEN,
  output logic [2:0]         AW_SIZE,
  output logic [1:0]         AW_BURST,
  output logic [2:0]         AW_SNOOP,
  output logic [1:0]         AW_DOMAIN,
  output logic               W_VALID,
  input  logic               W_READY,
  output logic [WIDTH_D-1:0] W_DATA,
  output logic               W_LAST,
  input  logic               B_VALID,
  output logic               B_READY,
  input  logic [1:0]         BRESP,
  output logic               WACK
);

  localparam int unsigned      LINE_BYTES = LINE_WORDS * (WIDTH_D / 8);
  localparam logic [WIDTH_A-1:0] ALIGN_MASK = ~(WIDTH_A'(LINE_BYTES - 1));
  localparam logic [2:0]       BEAT_SIZE  = 3'($clog2(WIDTH_D / 8));
  localparam logic [7:0]       LINE_LEN   = 8'(LINE_WORDS - 1);

  ace_state_e         state_q, state_d;
  req_op_e            op_q;
  logic [WIDTH_A-1:0] addr_q;
  logic               err_q, shared_q, dirty_q;
  logic               fill_valid_q;
  logic [IW-1:0]      fill_idx_q;
  logic [WIDTH_D-1:0] fill_data_q;

  logic               accept, r_beat, w_beat, is_mu;
  logic [IW-1:0]      beat_cnt;
  logic               beat_last, beat_full;
  logic               r_expect_last, r_misplaced;

  assign accept = (state_q == ST_IDLE) && req_valid;
  assign r_beat = (state_q == ST_R) && R_VALID;
  assign w_beat = (state_q == ST_W) && W_READY;
  assign is_mu  = (op_q == OP_MAKE_UNIQUE);

  ace_beat_counter #(.LINE_WORDS(LINE_WORDS)) u_beat_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .inc  (r_beat || w_beat),
    .cnt  (beat_cnt),
    .last (beat_last),
    .full (beat_full)
  );

  // MakeUnique is a single-beat burst, so its R_LAST belongs on beat 0.
  assign r_expect_last = is_mu ? (beat_cnt == '0) : beat_last;
  assign r_misplaced   = beat_full || (R_LAST != r_expect_last);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = (req_op_e'(req_op) == OP_WRITE_BACK) ? ST_AW : ST_AR;
      ST_AR:   if (AR_READY) state_d = ST_R;
      ST_R:    if (R_VALID && R_LAST) state_d = ST_ACK;
      ST_AW:   if (AW_READY) state_d = ST_W;
      ST_W:    if (W_READY && beat_last) state_d = ST_B;
      ST_B:    if (B_VALID) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_READ_SHARED;
      addr_q       <= '0;
      err_q        <= 1'b0;
      shared_q     <= 1'b0;
      dirty_q      <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_idx_q   <= '0;
      fill_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      fill_valid_q <= r_beat && !is_mu && !beat_full;
      if (accept) begin
        op_q     <= req_op_e'(req_op);
        addr_q   <= req_addr & ALIGN_MASK;
        err_q    <= 1'b0;
        shared_q <= 1'b0;
        dirty_q  <= 1'b0;
      end
      if (r_beat) begin
        fill_idx_q  <= beat_cnt;
        fill_data_q <= RDATA;
        shared_q    <= RRESP[3];
        dirty_q     <= RRESP[2];
        if ((RRESP[1:0] != 2'b00) || r_misplaced) err_q <= 1'b1;
      end
      if ((state_q == ST_B) && B_VALID && (BRESP != 2'b00)) err_q <= 1'b1;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign done        = (state_q == ST_ACK);
  assign RACK        = done && (op_q != OP_WRITE_BACK);
  assign WACK        = done && (op_q == OP_WRITE_BACK);
  assign resp_err    = err_q;
  assign resp_shared = shared_q;
  assign resp_dirty  = dirty_q;

  assign fill_valid = fill_valid_q;
  assign fill_idx   = fill_idx_q;
  assign fill_data  = fill_data_q;

  assign AR_VALID  = (state_q == ST_AR);
  assign AR_ADDR   = addr_q;
  assign AR_LEN    = is_mu ? 8'd0 : LINE_LEN;
  assign AR_SIZE   = BEAT_SIZE;
  assign AR_BURST  = BURST_INCR;
  assign AR_SNOOP  = ar_snoop_of(op_q);
  assign AR_DOMAIN = DOMAIN_INNER;
  assign R_READY   = (state_q == ST_R);

  assign AW_VALID  = (state_q == ST_AW);
  assign AW_ADDR   = addr_q;
  assign AW_LEN    = LINE_LEN;
  assign AW_SIZE   = BEAT_SIZE;
  assign AW_BURST  = BURST_INCR;
  assign AW_SNOOP  = AW_SNOOP_WRITE_BACK;
  assign AW_DOMAIN = DOMAIN_INNER;

  assign wb_idx  = beat_cnt;
  assign W_VALID = (state_q == ST_W);
  assign W_DATA  = wb_data;
  assign W_LAST  = beat_last;
  assign B_READY = (state_q == ST_B);

endmodule
